ap_line_sequencer: RTL and testbench
====================================

// Module: ap_line_sequencer
// PURPOSE
//  Upstream driver of the AP/Data line: accepts one decoded Brainfuck data op per valid/ready handshake.
//  Expands it into repeat-counted single-step requests (ApRequest/DataRequest/Dec/Zero).
//  Paces each step on the line's Ready, with a watchdog on every step.
//  Reports completion, the zero flag used by loop decisions ([ ]), and the cell value captured for output (.).
// PARAMETERS
//  DATA_W   12    width of line Data bus (3 dekatrons x 4 bits)
//  REP_W    4     width of RepCount; value 0 is treated as 1
//  TIMEOUT  1023  max Clk cycles waiting for Ready per step before Error
//  TO_W     10    watchdog counter width; must satisfy TIMEOUT < 2**TO_W
// PORTS
//  Clk        in   1       system clock, all logic on rising edge
//  Rst        in   1       synchronous reset, active-high
//  Op         in   3       opcode: 0 NOP,1 AP_INC,2 AP_DEC,3 DATA_INC,4 DATA_DEC,5 AP_CLR,6 DATA_CLR,7 PEEK
//  RepCount   in   REP_W   step count for INC/DEC ops; ignored by other ops
//  OpValid    in   1       Op/RepCount valid
//  OpReady    out  1       sequencer can accept op (IDLE and not Error)
//  ErrClear   in   1       clears sticky Error, returns to IDLE
//  ApRequest  out  1       one-cycle step request to AP counter
//  DataRequest out 1       one-cycle step request to Data counter
//  Dec        out  1       step direction, held stable from request cycle to step end
//  Zero       out  1       set-to-zero qualifier, driven with the request
//  LineReady  in   1       line idle/ready (combinational from line, includes ~requests)
//  LineDataZero in 1       current cell == 0
//  LineData   in   DATA_W  current cell value
//  Done       out  1       one-cycle pulse: op finished
//  ResultZero out  1       LineDataZero sampled on the Done cycle, held until next Done
//  PeekData   out  DATA_W  LineData captured at PEEK completion, held
//  Error      out  1       sticky watchdog error
// BEHAVIOUR
//  Reset: all outputs 0 (OpReady=0 on the reset cycle), state IDLE, counters 0; reset mid-op drops requests the same edge.
//  States: IDLE, ISSUE, GUARD, WAIT, FINISH, ERR.
//  IDLE: OpReady=1. On OpValid, latch Op and rem=(RepCount==0?1:RepCount).
//   - NOP/PEEK -> FINISH.
//   - Other ops, LineReady=1 -> ISSUE.
//   - Other ops, LineReady=0 -> stay in IDLE, op held latched, OpReady=0.
//  ISSUE (1 cycle):
//   - Assert exactly one of ApRequest (AP_*) or DataRequest (DATA_*).
//   - Dec=1 for *_DEC; Zero=1 for *_CLR; CLR ops force rem=1.
//   - Go to GUARD.
//  GUARD (1 cycle): requests low, LineReady ignored (line leaves IDLE), watchdog cleared -> WAIT.
//  WAIT: watchdog increments each cycle.
//   - LineReady=1: rem-=1; rem!=0 -> ISSUE; rem==0 -> FINISH.
//   - Watchdog reaches TIMEOUT -> ERR.
//  Step period: minimum 3 Clk per step (ISSUE, GUARD, WAIT with LineReady=1).
//  FINISH (1 cycle): Done=1, ResultZero<=LineDataZero, PeekData<=LineData if PEEK -> IDLE.
//  NOP latency: OpValid accept -> Done 1 cycle later.
//  ERR: Error=1, OpReady=0, no requests; ErrClear -> IDLE, Error=0; OpValid ignored.
//  Dec/Zero only change in ISSUE, stay stable through WAIT, and return to 0 in FINISH.
//  Never assert ApRequest and DataRequest together. Never issue a request while LineReady=0.
//  rem arithmetic is REP_W bits, no wrap: decrement happens only when rem>=1.
//  Simultaneous Rst and ErrClear: Rst wins.
// STRUCTURE
//  Shared package dekatron_pkg holds:
//   - op enum (AP_INC..PEEK)
//   - state enum
//   - DEKATRON_WIDTH and DATA_DEKATRON_NUM constants
//  One sub-module: step_watchdog (TO_W counter with clear/enable, expired flag at TIMEOUT).
// TESTING
//  Reset with OpValid=1 -> no requests, OpReady=1 the cycle after Rst falls.
//  AP_INC RepCount=3, LineReady high 2 cycles after each request -> 3 ApRequest pulses with Dec=0, one Done.
//  DATA_DEC RepCount=0 -> exactly 1 DataRequest with Dec=1; ResultZero = LineDataZero at Done.
//  AP_CLR RepCount=5 -> single ApRequest with Zero=1.
//  PEEK with LineData=12'h255 -> Done 1 cycle after accept, PeekData=12'h255, no requests.
//  DATA_INC, LineReady stuck 0 for 1023 cycles -> Error=1, OpReady=0.
//   Then ErrClear -> OpReady=1, Error=0.
//   Also: Rst asserted mid-WAIT -> IDLE next cycle with all outputs 0.

Source files
------------

// File: rtl/dekatron_pkg.sv
// Shared types for the dekatron AP/Data line sequencer.
// Opcode and FSM state encodings plus line geometry.
package dekatron_pkg;

   localparam int DEKATRON_WIDTH    = 4;
   localparam int DATA_DEKATRON_NUM = 3;

   typedef enum logic [2:0] {
      OP_NOP      = 3'd0,
      OP_AP_INC   = 3'd1,
      OP_AP_DEC   = 3'd2,
      OP_DATA_INC = 3'd3,
      OP_DATA_DEC = 3'd4,
      OP_AP_CLR   = 3'd5,
      OP_DATA_CLR = 3'd6,
      OP_PEEK     = 3'd7
   } op_t;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_GUARD,
      S_WAIT,
      S_FINISH,
      S_ERR
   } state_t;

   function automatic logic is_step(op_t op);
      return !(op inside {OP_NOP, OP_PEEK});
   endfunction

   function automatic logic is_ap(op_t op);
      return op inside {OP_AP_INC, OP_AP_DEC, OP_AP_CLR};
   endfunction

   function automatic logic is_dec(op_t op);
      return op inside {OP_AP_DEC, OP_DATA_DEC};
   endfunction

   function automatic logic is_clr(op_t op);
      return op inside {OP_AP_CLR, OP_DATA_CLR};
   endfunction

endpackage

// File: rtl/ap_line_sequencer_watchdog.sv
// Per-step watchdog: counts cycles spent waiting for the line.
// Expired flags the cycle in which the count would reach TIMEOUT.
module step_watchdog #(
   parameter int TIMEOUT = 1023,
   parameter int TO_W    = 10
) (
   input  logic Clk,
   input  logic Rst,
   input  logic Clear,
   input  logic Enable,
   output logic Expired
);

   localparam logic [TO_W-1:0] LAST = TO_W'(TIMEOUT - 1);

   logic [TO_W-1:0] count;

   assign Expired = Enable && (count == LAST);

   always_ff @(posedge Clk) begin
      if (Rst || Clear) begin
         count <= '0;
      end else if (Enable && !Expired) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/ap_line_sequencer.sv
// Expands decoded Brainfuck data ops into paced single-step requests
// on the AP/Data line, with completion, zero flag and peek capture.
module ap_line_sequencer
   import dekatron_pkg::*;
#(
   parameter int DATA_W  = DEKATRON_WIDTH * DATA_DEKATRON_NUM,
   parameter int REP_W   = 4,
   parameter int TIMEOUT = 1023,
   parameter int TO_W    = 10
) (
   input  logic              Clk,
   input  logic              Rst,
   input  logic [2:0]        Op,
   input  logic [REP_W-1:0]  RepCount,
   input  logic              OpValid,
   output logic              OpReady,
   input  logic              ErrClear,
   output logic              ApRequest,
   output logic              DataRequest,
   output logic              Dec,
   output logic              Zero,
   input  logic              LineReady,
   input  logic              LineDataZero,
   input  logic [DATA_W-1:0] LineData,
   output logic              Done,
   output logic              ResultZero,
   output logic [DATA_W-1:0] PeekData,
   output logic              Error
);

   state_t           state;
   op_t              op_q;
   op_t              op_in;
   op_t              iss_op;
   logic [REP_W-1:0] rem;
   logic [REP_W-1:0] rem_init;
   logic             pending;
   logic             accept;
   logic             go_issue;
   logic             go_finish;
   logic             wd_exp;

   step_watchdog #(
      .TIMEOUT (TIMEOUT),
      .TO_W    (TO_W)
   ) u_wd (
      .Clk     (Clk),
      .Rst     (Rst),
      .Clear   (state == S_GUARD),
      .Enable  (state == S_WAIT),
      .Expired (wd_exp)
   );

   always_comb begin
      op_in     = op_t'(Op);
      accept    = (state == S_IDLE) && !pending && OpReady && OpValid;
      iss_op    = accept ? op_in : op_q;
      rem_init  = (is_clr(op_in) || RepCount == '0) ? REP_W'(1) : RepCount;
      go_issue  = 1'b0;
      go_finish = 1'b0;
      unique case (state)
         S_IDLE: begin
            go_issue  = LineReady && (pending || (accept && is_step(op_in)));
            go_finish = accept && !is_step(op_in);
         end
         S_WAIT: begin
            go_issue  = LineReady && (rem > REP_W'(1));
            go_finish = LineReady && (rem <= REP_W'(1));
         end
         default: ;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         state       <= S_IDLE;
         op_q        <= OP_NOP;
         rem         <= '0;
         pending     <= 1'b0;
         OpReady     <= 1'b0;
         ApRequest   <= 1'b0;
         DataRequest <= 1'b0;
         Dec         <= 1'b0;
         Zero        <= 1'b0;
         Done        <= 1'b0;
         ResultZero  <= 1'b0;
         PeekData    <= '0;
         Error       <= 1'b0;
      end else begin
         ApRequest   <= 1'b0;
         DataRequest <= 1'b0;
         Done        <= 1'b0;
         if (go_issue) begin
            state       <= S_ISSUE;
            pending     <= 1'b0;
            OpReady     <= 1'b0;
            ApRequest   <= is_ap(iss_op);
            DataRequest <= !is_ap(iss_op);
            Dec         <= is_dec(iss_op);
            Zero        <= is_clr(iss_op);
         end else if (go_finish) begin
            state      <= S_FINISH;
            OpReady    <= 1'b0;
            Done       <= 1'b1;
            Dec        <= 1'b0;
            Zero       <= 1'b0;
            ResultZero <= LineDataZero;
            if (iss_op == OP_PEEK) begin
               PeekData <= LineData;
            end
         end else begin
            unique case (state)
               S_IDLE: begin
                  // a step op accepted while the line is busy waits here
                  if (accept) begin
                     pending <= 1'b1;
                     OpReady <= 1'b0;
                  end else begin
                     OpReady <= !pending;
                  end
               end
               S_ISSUE: state <= S_GUARD;
               S_GUARD: state <= S_WAIT;
               S_WAIT: begin
                  if (wd_exp) begin
                     state <= S_ERR;
                     Error <= 1'b1;
                     Dec   <= 1'b0;
                     Zero  <= 1'b0;
                  end
               end
               S_FINISH: begin
                  state   <= S_IDLE;
                  OpReady <= 1'b1;
               end
               S_ERR: begin
                  if (ErrClear) begin
                     state   <= S_IDLE;
                     Error   <= 1'b0;
                     OpReady <= 1'b1;
                  end
               end
               default: state <= S_IDLE;
            endcase
         end
         if (accept) begin
            op_q <= op_in;
            rem  <= rem_init;
         end else if (state == S_WAIT && LineReady && rem != '0) begin
            rem <= rem - 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_ap_line_sequencer.sv
// Bench for ap_line_sequencer: line BFM plus op-level reference model.
// Directed scenarios followed by randomized op sequences.
module tb_ap_line_sequencer;
   import dekatron_pkg::*;

   localparam int DATA_W  = 12;
   localparam int REP_W   = 4;
   localparam int TIMEOUT = 1023;
   localparam int TO_W    = 10;
   localparam int NCELL   = 16;

   logic              Clk = 1'b0;
   logic              Rst = 1'b1;
   logic [2:0]        Op = 3'd0;
   logic [REP_W-1:0]  RepCount = '0;
   logic              OpValid = 1'b0;
   logic              ErrClear = 1'b0;
   logic              OpReady;
   logic              ApRequest;
   logic              DataRequest;
   logic              Dec;
   logic              Zero;
   logic              LineReady;
   logic              LineDataZero;
   logic [DATA_W-1:0] LineData;
   logic              Done;
   logic              ResultZero;
   logic [DATA_W-1:0] PeekData;
   logic              Error;

   int checks = 0;
   int failures = 0;

   // line side
   logic [3:0]        l_ap = 4'd0;
   logic [DATA_W-1:0] l_mem [NCELL] = '{default: '0};
   int                busy = 0;
   int                delay_fix = 0;
   bit                hang = 1'b0;
   bit                rdy_edge = 1'b1;
   bit                dec_q = 1'b0;
   bit                zero_q = 1'b0;
   bit                pre_req = 1'b0;
   logic [DATA_W-1:0] pre_val = '0;
   int                n_ap = 0;
   int                n_data = 0;
   int                n_done = 0;
   int                n_viol = 0;

   // op-level reference model
   logic [3:0]        m_ap = 4'd0;
   logic [DATA_W-1:0] m_mem [NCELL] = '{default: '0};
   logic [DATA_W-1:0] exp_peek = '0;

   ap_line_sequencer #(
      .DATA_W  (DATA_W),
      .REP_W   (REP_W),
      .TIMEOUT (TIMEOUT),
      .TO_W    (TO_W)
   ) dut (
      .Clk          (Clk),
      .Rst          (Rst),
      .Op           (Op),
      .RepCount     (RepCount),
      .OpValid      (OpValid),
      .OpReady      (OpReady),
      .ErrClear     (ErrClear),
      .ApRequest    (ApRequest),
      .DataRequest  (DataRequest),
      .Dec          (Dec),
      .Zero         (Zero),
      .LineReady    (LineReady),
      .LineDataZero (LineDataZero),
      .LineData     (LineData),
      .Done         (Done),
      .ResultZero   (ResultZero),
      .PeekData     (PeekData),
      .Error        (Error)
   );

   always #5 Clk = ~Clk;

   assign LineReady    = (busy == 0) && !hang && !ApRequest && !DataRequest;
   assign LineData     = l_mem[l_ap];
   assign LineDataZero = (LineData == '0);

   always @(posedge Clk) rdy_edge <= LineReady;

   always @(negedge Clk) begin
      if (pre_req) l_mem[l_ap] = pre_val;
      if (Done) n_done++;
      if (ApRequest && DataRequest) n_viol++;
      if (ApRequest || DataRequest) begin
         if (!rdy_edge) n_viol++;
         dec_q  = Dec;
         zero_q = Zero;
         busy   = (delay_fix != 0) ? delay_fix : int'($urandom_range(1, 4));
         if (ApRequest) begin
            n_ap++;
            l_ap = Zero ? 4'd0 : (Dec ? l_ap - 4'd1 : l_ap + 4'd1);
         end else begin
            n_data++;
            l_mem[l_ap] = Zero ? '0 :
                          (Dec ? l_mem[l_ap] - 12'd1 : l_mem[l_ap] + 12'd1);
         end
      end else if (busy > 0) begin
         if (!Rst && (Dec !== dec_q || Zero !== zero_q)) n_viol++;
         busy--;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   function automatic int steps(input logic [2:0] op, input logic [3:0] rep);
      if (op == OP_NOP || op == OP_PEEK) return 0;
      if (op == OP_AP_CLR || op == OP_DATA_CLR) return 1;
      return (rep == 4'd0) ? 1 : int'(rep);
   endfunction

   task automatic model(input logic [2:0] op, input int n);
      case (op)
         OP_AP_INC:   m_ap = m_ap + 4'(n);
         OP_AP_DEC:   m_ap = m_ap - 4'(n);
         OP_DATA_INC: m_mem[m_ap] = m_mem[m_ap] + 12'(n);
         OP_DATA_DEC: m_mem[m_ap] = m_mem[m_ap] - 12'(n);
         OP_AP_CLR:   m_ap = 4'd0;
         OP_DATA_CLR: m_mem[m_ap] = '0;
         OP_PEEK:     exp_peek = m_mem[m_ap];
         default: ;
      endcase
   endtask

   task automatic run_op(input logic [2:0] op, input logic [3:0] rep);
      int a0 = n_ap;
      int d0 = n_data;
      int k0 = n_done;
      int v0 = n_viol;
      int n = steps(op, rep);
      int ea = (op inside {OP_AP_INC, OP_AP_DEC, OP_AP_CLR}) ? n : 0;
      int ed = (op inside {OP_DATA_INC, OP_DATA_DEC, OP_DATA_CLR}) ? n : 0;
      int t = 0;
      bit acc = 1'b0;
      Op = op;
      RepCount = rep;
      OpValid = 1'b1;
      while (!acc && t < 50) begin
         acc = OpReady;
         tick();
         t++;
      end
      OpValid = 1'b0;
      chk("accept", 32'(acc), 1);
      t = 0;
      while (!Done && t < 200) begin
         tick();
         t++;
      end
      model(op, n);
      chk("done", 32'(Done), 1);
      if (n == 0) chk("latency", t, 0);
      else chk("step_period", 32'(t >= 3 * n), 1);
      chk("dec_at_done", 32'(Dec), 0);
      chk("zero_at_done", 32'(Zero), 0);
      chk("result_zero", 32'(ResultZero), 32'(m_mem[m_ap] == '0));
      chk("peek_data", 32'(PeekData), 32'(exp_peek));
      tick();
      chk("ap_requests", n_ap - a0, ea);
      chk("data_requests", n_data - d0, ed);
      chk("done_pulses", n_done - k0, 1);
      chk("protocol", n_viol - v0, 0);
      chk("ap_value", 32'(l_ap), 32'(m_ap));
      chk("cell_value", 32'(LineData), 32'(m_mem[m_ap]));
   endtask

   initial begin
      int t;
      int d0;
      int k0;
      // reset held with a pending op request
      Rst = 1'b1;
      Op = OP_AP_INC;
      RepCount = 4'd3;
      OpValid = 1'b1;
      repeat (3) tick();
      chk("rst_ready", 32'(OpReady), 0);
      chk("rst_req", 32'(ApRequest | DataRequest), 0);
      chk("rst_done", 32'(Done), 0);
      chk("rst_error", 32'(Error), 0);
      chk("rst_peek", 32'(PeekData), 0);
      Rst = 1'b0;
      tick();
      chk("ready_after_rst", 32'(OpReady), 1);
      chk("no_req_in_rst", n_ap + n_data, 0);
      OpValid = 1'b0;
      tick();

      delay_fix = 2;
      run_op(OP_AP_INC, 4'd3);
      run_op(OP_DATA_INC, 4'd1);
      run_op(OP_DATA_DEC, 4'd0);
      run_op(OP_AP_CLR, 4'd5);
      run_op(OP_NOP, 4'd9);
      delay_fix = 0;

      pre_val = 12'h255;
      pre_req = 1'b1;
      tick();
      pre_req = 1'b0;
      m_mem[m_ap] = 12'h255;
      run_op(OP_PEEK, 4'd0);
      chk("peek_255", 32'(PeekData), 32'h255);

      // step op offered while the line is busy
      d0 = n_data;
      hang = 1'b1;
      Op = OP_DATA_INC;
      RepCount = 4'd2;
      OpValid = 1'b1;
      chk("pend_ready_in", 32'(OpReady), 1);
      tick();
      OpValid = 1'b0;
      repeat (5) tick();
      chk("pend_ready_low", 32'(OpReady), 0);
      chk("pend_no_req", n_data - d0, 0);
      hang = 1'b0;
      t = 0;
      while (!Done && t < 100) begin
         tick();
         t++;
      end
      model(OP_DATA_INC, 2);
      chk("pend_done", 32'(Done), 1);
      tick();
      chk("pend_reqs", n_data - d0, 2);
      chk("pend_cell", 32'(LineData), 32'(m_mem[m_ap]));

      // watchdog
      d0 = n_data;
      Op = OP_DATA_INC;
      RepCount = 4'd1;
      OpValid = 1'b1;
      chk("to_ready_in", 32'(OpReady), 1);
      tick();
      OpValid = 1'b0;
      hang = 1'b1;
      t = 0;
      while (!Error && t < 1100) begin
         tick();
         t++;
      end
      model(OP_DATA_INC, 1);
      chk("to_error", 32'(Error), 1);
      chk("to_time", 32'(t >= TIMEOUT + 1 && t <= TIMEOUT + 3), 1);
      chk("to_ready", 32'(OpReady), 0);
      k0 = n_done;
      Op = OP_NOP;
      OpValid = 1'b1;
      repeat (4) tick();
      chk("err_ignores_op", n_done - k0, 0);
      chk("err_sticky", 32'(Error), 1);
      chk("err_one_req", n_data - d0, 1);
      OpValid = 1'b0;
      hang = 1'b0;
      ErrClear = 1'b1;
      tick();
      ErrClear = 1'b0;
      chk("clr_error", 32'(Error), 0);
      chk("clr_ready", 32'(OpReady), 1);

      // reset in the middle of a wait
      d0 = n_data;
      Op = OP_DATA_DEC;
      RepCount = 4'd3;
      OpValid = 1'b1;
      tick();
      OpValid = 1'b0;
      hang = 1'b1;
      repeat (4) tick();
      chk("wait_dec", 32'(Dec), 1);
      Rst = 1'b1;
      tick();
      chk("midrst_outs", 32'({OpReady, ApRequest, DataRequest, Dec, Zero,
                              Done, ResultZero, Error}), 0);
      chk("midrst_peek", 32'(PeekData), 0);
      Rst = 1'b0;
      hang = 1'b0;
      exp_peek = '0;
      tick();
      chk("midrst_ready", 32'(OpReady), 1);
      chk("midrst_reqs", n_data - d0, 1);
      model(OP_DATA_DEC, 1);

      for (int i = 0; i < 30; i++) begin
         run_op(3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "time limit");
   end

endmodule
